audio_sram_recplay: RTL and testbench
=====================================

# audio_sram_recplay

Sample store between the codec-side audio bus and the board's 16-bit asynchronous SRAM. In record mode it accepts 32-bit stereo samples (left in [31:16], right in [15:0]) over a ready/valid handshake and writes each as two SRAM words. In play mode it reads them back in order and offers them to the audio bus over the same handshake. Mode is selected by single-cycle command pulses from the top-level control FSM.

## Interface
- ADDR_W, 20: SRAM word-address width. Capacity is CAP = 2^(ADDR_W-1) stereo samples.

- i_clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset; one clock domain
- i_start_rec  in  1  pulse: start recording at sample 0
- i_start_play  in  1  pulse: start playback from sample 0
- i_stop  in  1  pulse: end the current operation
- o_busy  out  1  high whenever state != IDLE
- o_done  out  1  one-cycle pulse when an operation ends
- o_rec_len  out  ADDR_W  number of samples stored by the last recording
- i_record_audio_data  in  32  sample from the audio bus
- i_record_audio_valid  in  1  sample valid
- o_record_audio_ready  out  1  store can accept a sample
- o_play_audio_data  out  32  sample to the audio bus
- o_play_audio_valid  out  1  sample valid
- i_play_audio_ready  in  1  audio bus consumed the sample
- o_sram_addr  out  ADDR_W  word address
- io_sram_dq  inout  16  data, high-Z unless writing
- o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_lb_n, o_sram_ub_n  out  1 each  active-low SRAM controls

## Operation
- States: IDLE, REC_WAIT, REC_WR_HI, REC_WR_LO, PLAY_RD_HI, PLAY_RD_LO, PLAY_WAIT.
- Counters: ptr (ADDR_W-1 bits) is the sample index. rec_len (ADDR_W bits) is held in a register.
- IDLE:
  - i_start_rec: ptr=0, rec_len=0, go to REC_WAIT.
  - Else i_start_play with rec_len!=0: ptr=0, go to PLAY_RD_HI.
  - i_start_play with rec_len==0: stay in IDLE and pulse o_done.
  - start_rec wins over start_play when both arrive together.
  - Starts are ignored outside IDLE. i_stop in IDLE is ignored.
- REC_WAIT:
  - o_record_audio_ready=1 (registered).
  - On valid&ready: latch data into buf and go to REC_WR_HI.
  - i_stop without valid: go to IDLE and pulse o_done.
  - If i_stop and valid arrive in the same cycle, the sample is accepted and written, then the block goes to IDLE.
- REC_WR_HI: addr={ptr,0}, dq=buf[31:16], we_n=0.
- REC_WR_LO: addr={ptr,1}, dq=buf[15:0], we_n=0. Then ptr++ and rec_len++.
  - Go to IDLE (with o_done) if rec_len+1==CAP or if a stop is pending.
  - Otherwise go to REC_WAIT.
- i_stop arriving during the write states is latched as a pending stop. The write always completes.
- PLAY_RD_HI: addr={ptr,0}, oe_n=0. dq is captured into o_play_audio_data[31:16] at the end of the cycle.
- PLAY_RD_LO: addr={ptr,1}, oe_n=0. dq is captured into [15:0]. Go to PLAY_WAIT.
- PLAY_WAIT:
  - o_play_audio_valid=1. Data is held stable until ready.
  - On ready&valid: if ptr+1==rec_len, go to IDLE and pulse o_done. Otherwise ptr++ and go to PLAY_RD_HI.
- i_stop during any play state: go to IDLE next cycle, clear valid, pulse o_done.
- SRAM control rules:
  - ce_n=0 outside IDLE.
  - lb_n=ub_n=0 outside IDLE.
  - we_n=0 only in the write states.
  - oe_n=0 only in the read states.
  - dq is driven only while we_n=0.
- rec_len is untouched by playback and persists until the next i_start_rec.

## Timing
- Reset values:
  - state=IDLE, ptr=0, rec_len=0.
  - o_busy=0, o_done=0, o_record_audio_ready=0.
  - o_play_audio_valid=0, o_play_audio_data=0.
  - we_n=oe_n=ce_n=lb_n=ub_n=1, o_sram_addr=0, dq high-Z.
- Reset mid-write aborts immediately; rec_len reads 0 afterwards.
- Handshake outputs (ready, valid, data) are registered. SRAM strobes are decoded from the registered state and ptr.
- Record flow:
  - o_record_audio_ready rises one cycle after i_start_rec.
  - It falls the cycle after acceptance.
  - It returns 3 cycles after acceptance: WR_HI, WR_LO, then REC_WAIT with ready=1.
  - The minimum sample period is 3 cycles.
- Play flow:
  - Valid rises 3 cycles after i_start_play (RD_HI, RD_LO, WAIT).
  - It falls the cycle after ready.
  - Valid rises again 3 cycles later.
- The upstream audio bus may present valid for only one cycle. Acceptance is evaluated every cycle ready is high.
- SRAM read access time must be ≤ one i_clk period.
- o_done is a single-cycle pulse, coincident with the first IDLE cycle.

## Test plan
- Record 4 samples 0x11112222, 0x33334444, 0x55556666, 0x77778888, then i_stop in REC_WAIT -> SRAM words 0..7 are 1111, 2222, … 8888; o_rec_len=4; one o_done.
- Play after that with i_play_audio_ready pulsed every 10 cycles -> the same 4 words appear in order, each held stable until ready; o_done after the 4th; o_busy=0.
- i_start_play with rec_len=0 -> no SRAM access, valid stays 0, o_done the next cycle.
- ADDR_W=4 (CAP=8), continuous valid -> exactly 8 samples written, auto-stop, o_rec_len=8, ready never reasserts.
- i_stop in REC_WR_HI -> the write completes (both words), rec_len increments, then IDLE; i_start_rec+i_start_play together -> recording starts.
- Assert i_rst_n=0 in PLAY_WAIT -> valid=0, all SRAM strobes=1, dq=Z, o_rec_len=0 immediately.

Source files
------------

// File: rtl/audio_sram_recplay.sv
// Stereo sample store between the audio bus and a 16-bit asynchronous SRAM.
// Record mode writes each 32-bit sample (L in [31:16], R in [15:0]) as two
// SRAM words; play mode reads them back in order onto the audio bus.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_start_rec/i_start_play/i_stop  single-cycle command pulses
//   o_busy, o_done, o_rec_len      status
//   i_record_audio_*/o_record_audio_ready  record-side ready/valid
//   o_play_audio_*/i_play_audio_ready      play-side ready/valid
//   o_sram_addr, io_sram_dq, o_sram_*_n    SRAM pins (active-low strobes)
module audio_sram_recplay #(
  parameter int unsigned ADDR_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start_rec,
  input  logic              i_start_play,
  input  logic              i_stop,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_rec_len,
  input  logic [31:0]       i_record_audio_data,
  input  logic              i_record_audio_valid,
  output logic              o_record_audio_ready,
  output logic [31:0]       o_play_audio_data,
  output logic              o_play_audio_valid,
  input  logic              i_play_audio_ready,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  wire  [15:0]       io_sram_dq,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_ce_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  localparam int unsigned PTR_W = ADDR_W - 1;
  localparam int unsigned CAP   = 1 << PTR_W;

  typedef enum logic [2:0] {
    IDLE, REC_WAIT, REC_WR_HI, REC_WR_LO, PLAY_RD_HI, PLAY_RD_LO, PLAY_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] rec_len_q, rec_len_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       pdata_q, pdata_d;
  logic              stop_pend_q, stop_pend_d;
  logic              done_q, done_d;
  logic              ready_q, valid_q;
  logic              in_play;
  logic              wr_act, rd_act;
  logic [15:0]       wdata;

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rec_len_q   <= '0;
      buf_q       <= '0;
      pdata_q     <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rec_len_q   <= rec_len_d;
      buf_q       <= buf_d;
      pdata_q     <= pdata_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
      ready_q     <= (state_d == REC_WAIT);
      valid_q     <= (state_d == PLAY_WAIT);
    end
  end

  assign in_play = (state_q == PLAY_RD_HI) || (state_q == PLAY_RD_LO) ||
                   (state_q == PLAY_WAIT);

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rec_len_d   = rec_len_q;
    buf_d       = buf_q;
    pdata_d     = pdata_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (i_start_rec) begin
          ptr_d     = '0;
          rec_len_d = '0;
          state_d   = REC_WAIT;
        end else if (i_start_play) begin
          if (rec_len_q != '0) begin
            ptr_d   = '0;
            state_d = PLAY_RD_HI;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      REC_WAIT: begin
        if (i_record_audio_valid && ready_q) begin
          buf_d   = i_record_audio_data;
          state_d = REC_WR_HI;
          // a simultaneous stop still lets this sample be written
          if (i_stop) stop_pend_d = 1'b1;
        end else if (i_stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      REC_WR_HI: begin
        state_d = REC_WR_LO;
        if (i_stop) stop_pend_d = 1'b1;
      end
      REC_WR_LO: begin
        ptr_d     = ptr_q + PTR_W'(1);
        rec_len_d = rec_len_q + ADDR_W'(1);
        if ((rec_len_q + ADDR_W'(1) == ADDR_W'(CAP)) || stop_pend_q || i_stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = REC_WAIT;
        end
      end
      PLAY_RD_HI: begin
        pdata_d[31:16] = io_sram_dq;
        state_d        = PLAY_RD_LO;
      end
      PLAY_RD_LO: begin
        pdata_d[15:0] = io_sram_dq;
        state_d       = PLAY_WAIT;
      end
      PLAY_WAIT: begin
        if (valid_q && i_play_audio_ready) begin
          if (ADDR_W'(ptr_q) + ADDR_W'(1) == rec_len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            ptr_d   = ptr_q + PTR_W'(1);
            state_d = PLAY_RD_HI;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // stop aborts playback from any play state
    if (in_play && i_stop) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end

  // SRAM pin decode from the registered state and pointer
  assign wr_act = (state_q == REC_WR_HI) || (state_q == REC_WR_LO);
  assign rd_act = (state_q == PLAY_RD_HI) || (state_q == PLAY_RD_LO);
  assign wdata  = (state_q == REC_WR_HI) ? buf_q[31:16] : buf_q[15:0];

  always_comb begin
    o_sram_addr = '0;
    case (state_q)
      IDLE:                   o_sram_addr = '0;
      REC_WR_LO, PLAY_RD_LO:  o_sram_addr = {ptr_q, 1'b1};
      default:                o_sram_addr = {ptr_q, 1'b0};
    endcase
  end

  assign io_sram_dq  = wr_act ? wdata : 16'hzzzz;
  assign o_sram_we_n = ~wr_act;
  assign o_sram_oe_n = ~rd_act;
  assign o_sram_ce_n = (state_q == IDLE);
  assign o_sram_lb_n = (state_q == IDLE);
  assign o_sram_ub_n = (state_q == IDLE);

  assign o_busy               = (state_q != IDLE);
  assign o_done               = done_q;
  assign o_rec_len            = rec_len_q;
  assign o_record_audio_ready = ready_q;
  assign o_play_audio_valid   = valid_q;
  assign o_play_audio_data    = pdata_q;

endmodule

// File: tb/tb_audio_sram_recplay.sv
// Scoreboard bench for audio_sram_recplay (ADDR_W=4, 8-sample capacity)
// with a behavioural SRAM model.
module tb_audio_sram_recplay;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CAP    = 8;

  logic              clk, rst_n;
  logic              start_rec, start_play, stop_i;
  logic              busy, done;
  logic [ADDR_W-1:0] rec_len;
  logic [31:0]       rec_data;
  logic              rec_valid, rec_ready;
  logic [31:0]       play_data;
  logic              play_valid, play_ready;
  logic [ADDR_W-1:0] sram_addr;
  wire  [15:0]       sram_dq;
  logic              we_n, oe_n, ce_n, lb_n, ub_n;

  audio_sram_recplay #(.ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_start_rec(start_rec), .i_start_play(start_play), .i_stop(stop_i),
    .o_busy(busy), .o_done(done), .o_rec_len(rec_len),
    .i_record_audio_data(rec_data), .i_record_audio_valid(rec_valid),
    .o_record_audio_ready(rec_ready),
    .o_play_audio_data(play_data), .o_play_audio_valid(play_valid),
    .i_play_audio_ready(play_ready),
    .o_sram_addr(sram_addr), .io_sram_dq(sram_dq),
    .o_sram_we_n(we_n), .o_sram_oe_n(oe_n), .o_sram_ce_n(ce_n),
    .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM model
  logic [15:0] mem [0:15];
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;
  always @(posedge clk) if (!ce_n && !we_n) mem[sram_addr] <= sram_dq;

  int n_cmp = 0, n_err = 0;
  int done_cnt = 0, oe_cnt = 0, valid_cnt = 0, rdy_cnt = 0;
  logic [31:0] rec_q [$];
  logic [31:0] exp_q [$];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: records accepted samples, scores played samples
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (!oe_n) oe_cnt++;
      if (play_valid) valid_cnt++;
      if (rec_ready) rdy_cnt++;
      if (rec_valid && rec_ready) rec_q.push_back(rec_data);
      if (play_valid && prev_hold) check("play_hold", 64'(play_data), 64'(prev_data));
      if (play_valid && play_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL play_extra: got %0h expected no sample", play_data);
        end else begin
          check("play_data", 64'(play_data), 64'(exp_q.pop_front()));
        end
      end
      prev_hold = play_valid && !play_ready;
      prev_data = play_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic r, input logic p);
    start_rec = r; start_play = p;
    tick;
    start_rec = 1'b0; start_play = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int b = 0;
    while (busy && b < 400) begin tick; b++; end
    if (busy) begin
      n_cmp++; n_err++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, b);
    end
  endtask

  task automatic record(input logic [31:0] s[$], input int gap_max);
    for (int k = 0; k < s.size(); k++) begin
      repeat ($urandom_range(gap_max, 0)) tick;
      rec_data = s[k]; rec_valid = 1'b1;
      for (int b = 0; b < 50 && !rec_ready; b++) tick;
      if (!rec_ready) begin
        n_cmp++; n_err++;
        $display("FAIL rec_ready_wait: got 0 expected 1");
      end
      tick;
      rec_valid = 1'b0;
    end
  endtask

  task automatic stop_in_wait;
    for (int b = 0; b < 50 && !rec_ready; b++) tick;
    stop_i = 1'b1; tick; stop_i = 1'b0;
  endtask

  task automatic check_sram(input logic [31:0] s[$]);
    logic [31:0] w;
    for (int i = 0; i < s.size(); i++) begin
      w = s[i];
      check("sram_hi", 64'(mem[2*i]),   64'(w[31:16]));
      check("sram_lo", 64'(mem[2*i+1]), 64'(w[15:0]));
    end
  endtask

  // mode 0: ready pulsed every `period` cycles, mode 1: random ready
  task automatic play_run(input int mode, input int period, input string name);
    int d0 = done_cnt;
    exp_q = rec_q;
    pulse(1'b0, 1'b1);
    for (int c = 0; c < 600 && busy; c++) begin
      play_ready = (mode == 1) ? 1'($urandom_range(1, 0)) : (c % period == period - 1);
      tick;
    end
    play_ready = 1'b0;
    wait_idle(name);
    tick;
    check({name, "_all"},  64'(exp_q.size()), 64'(0));
    check({name, "_done"}, 64'(done_cnt - d0), 64'(1));
    check({name, "_len"},  64'(rec_len), 64'(rec_q.size()));
  endtask

  initial begin
    logic [31:0] fixed [$];
    logic [31:0] rnd [$];
    int d0, r0, n;
    fixed = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst_n = 1'b0; start_rec = 0; start_play = 0; stop_i = 0;
    rec_data = '0; rec_valid = 0; play_ready = 0;
    repeat (3) tick;
    check("rst_busy",  64'(busy), 64'(0));
    check("rst_done",  64'(done), 64'(0));
    check("rst_ready", 64'(rec_ready), 64'(0));
    check("rst_valid", 64'(play_valid), 64'(0));
    check("rst_data",  64'(play_data), 64'(0));
    check("rst_strb",  64'({we_n, oe_n, ce_n, lb_n, ub_n}), 64'(5'b11111));
    check("rst_addr",  64'(sram_addr), 64'(0));
    check("rst_len",   64'(rec_len), 64'(0));
    rst_n = 1'b1;
    tick;

    // Play with nothing recorded
    pulse(1'b0, 1'b1);
    check("empty_done", 64'(done), 64'(1));
    check("empty_busy", 64'(busy), 64'(0));
    repeat (5) tick;
    check("empty_oe",    64'(oe_cnt), 64'(0));
    check("empty_valid", 64'(valid_cnt), 64'(0));

    // Fixed 4-sample recording stopped in REC_WAIT
    rec_q.delete(); d0 = done_cnt;
    pulse(1'b1, 1'b0);
    check("rec_ready_rise", 64'(rec_ready), 64'(1));
    record(fixed, 3);
    stop_in_wait;
    wait_idle("rec4");
    tick;
    check("rec4_len",  64'(rec_len), 64'(4));
    check("rec4_done", 64'(done_cnt - d0), 64'(1));
    check_sram(fixed);
    play_run(0, 10, "play4");

    // Random-length recording and random-ready playback
    for (int it = 0; it < 3; it++) begin
      n = $urandom_range(7, 1);
      rnd.delete();
      for (int i = 0; i < n; i++) rnd.push_back($urandom);
      rec_q.delete(); d0 = done_cnt;
      pulse(1'b1, 1'b0);
      record(rnd, 4);
      stop_in_wait;
      wait_idle("recr");
      tick;
      check("recr_len",  64'(rec_len), 64'(n));
      check("recr_done", 64'(done_cnt - d0), 64'(1));
      check_sram(rnd);
      play_run(1, 1, "playr");
    end

    // Continuous valid until capacity auto-stop
    rec_q.delete(); d0 = done_cnt; r0 = rdy_cnt;
    pulse(1'b1, 1'b0);
    for (int c = 0; c < 60; c++) begin
      rec_valid = 1'b1; rec_data = $urandom;
      tick;
    end
    rec_valid = 1'b0;
    check("cap_count", 64'(rec_q.size()), 64'(CAP));
    check("cap_len",   64'(rec_len), 64'(CAP));
    check("cap_busy",  64'(busy), 64'(0));
    check("cap_done",  64'(done_cnt - d0), 64'(1));
    check("cap_ready", 64'(rdy_cnt - r0), 64'(CAP));
    check_sram(rec_q);
    play_run(1, 1, "playcap");

    // Simultaneous starts record; stop during REC_WR_HI still completes the write
    rec_q.delete(); d0 = done_cnt;
    pulse(1'b1, 1'b1);
    check("both_ready", 64'(rec_ready), 64'(1));
    check("both_valid", 64'(play_valid), 64'(0));
    rec_data = $urandom; rec_valid = 1'b1;
    tick;
    rec_valid = 1'b0; stop_i = 1'b1;
    tick;
    stop_i = 1'b0;
    wait_idle("stophi");
    tick;
    check("stophi_len",  64'(rec_len), 64'(1));
    check("stophi_done", 64'(done_cnt - d0), 64'(1));
    check_sram(rec_q);

    // Reset while a sample waits for the audio bus
    pulse(1'b0, 1'b1);
    for (int b = 0; b < 20 && !play_valid; b++) tick;
    check("pre_rst_valid", 64'(play_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(play_valid), 64'(0));
    check("mid_rst_strb",  64'({we_n, oe_n, ce_n, lb_n, ub_n}), 64'(5'b11111));
    check("mid_rst_len",   64'(rec_len), 64'(0));
    check("mid_rst_busy",  64'(busy), 64'(0));
    tick;
    rst_n = 1'b1;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
